// File: rtl/rc5_key_mix.sv
// RC5 key expansion, second half: loads the L words, seeds the S table with P/Q,
// runs the 3*max(t,c) mixing loop and then serves the expanded S table on a read port.
module rc5_key_mix #(
   parameter int          w        = 32,
   parameter int          w_log    = 5,
   parameter int          r        = 12,
   parameter int          t        = 26,
   parameter int          t_length = 5,
   parameter int          c        = 4,
   parameter int          c_length = 2,
   parameter logic [31:0] P        = 32'hB7E15163,
   parameter logic [31:0] Q        = 32'h9E3779B9
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [c_length-1:0] L_address,
   input  logic [w-1:0]        L_sub_i,
   input  logic [t_length-1:0] s_rd_addr,
   output logic [w-1:0]        s_rd_data,
   output logic [2:0]          state_dbg
);

   // Handshake: start is a one-cycle request honoured only in IDLE or DONE; busy
   // covers LOAD_L..MIX, done holds the result valid until the next accepted start.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_L = 3'd1,
      INIT_S = 3'd2,
      MIX    = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int N_MIX = 3 * ((t > c) ? t : c);
   localparam int CNT_W = $clog2(N_MIX + 1);

   localparam logic [CNT_W-1:0]    LOAD_LAST = CNT_W'(c - 1);
   localparam logic [CNT_W-1:0]    INIT_LAST = CNT_W'(t - 1);
   localparam logic [CNT_W-1:0]    MIX_LAST  = CNT_W'(N_MIX - 1);
   localparam logic [t_length-1:0] I_LAST    = t_length'(t - 1);
   localparam logic [c_length-1:0] J_LAST    = c_length'(c - 1);
   localparam logic [t_length:0]   T_EXT     = (t_length + 1)'(t);

   state_t              state, next_state;
   logic [CNT_W-1:0]    cnt;
   logic [t_length-1:0] i;
   logic [c_length-1:0] j;
   logic [w-1:0]        a, b;
   logic [w-1:0]        s_mem [t];
   logic [w-1:0]        l_mem [c];

   logic [w-1:0]        a_new, ab_sum, b_new;
   logic [t_length-1:0] init_idx, init_prev;
   logic [c_length-1:0] load_idx;

   function automatic logic [w-1:0] rotl(input logic [w-1:0] x, input logic [w_log-1:0] n);
      logic [2*w-1:0] d;
      d = {x, x} << n;
      return d[2*w-1:w];
   endfunction

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = LOAD_L;
         LOAD_L:  if (cnt == LOAD_LAST) next_state = INIT_S;
         INIT_S:  if (cnt == INIT_LAST) next_state = MIX;
         MIX:     if (cnt == MIX_LAST) next_state = DONE;
         DONE:    if (start) next_state = LOAD_L;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      a_new     = rotl(s_mem[i] + a + b, w_log'(3));
      ab_sum    = a_new + b;
      b_new     = rotl(l_mem[j] + ab_sum, ab_sum[w_log-1:0]);
      init_idx  = cnt[t_length-1:0];
      init_prev = init_idx - 1'b1;
      load_idx  = cnt[c_length-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         i     <= '0;
         j     <= '0;
         a     <= '0;
         b     <= '0;
      end else begin
         state <= next_state;
         if (state != next_state) cnt <= '0;
         else if (busy)           cnt <= cnt + 1'b1;
         case (state)
            INIT_S: begin
               i <= '0;
               j <= '0;
               a <= '0;
               b <= '0;
            end
            MIX: begin
               a <= a_new;
               b <= b_new;
               i <= (i == I_LAST) ? '0 : i + 1'b1;
               j <= (j == J_LAST) ? '0 : j + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Table storage is never cleared; writes are simply suppressed while rst is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         case (state)
            LOAD_L: l_mem[load_idx] <= L_sub_i;
            INIT_S: s_mem[init_idx] <= (init_idx == '0) ? P : s_mem[init_prev] + Q;
            MIX: begin
               s_mem[i] <= a_new;
               l_mem[j] <= b_new;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state == LOAD_L) || (state == INIT_S) || (state == MIX);
   assign done      = (state == DONE);
   assign L_address = (state == LOAD_L) ? load_idx : '0;
   assign s_rd_data = ({1'b0, s_rd_addr} < T_EXT) ? s_mem[s_rd_addr] : '0;
   assign state_dbg = state;

endmodule

// File: tb/tb_rc5_key_mix.sv
// Directed bench for rc5_key_mix: golden RC5 key schedule model feeds an expected
// queue that is drained against the S read port once each expansion finishes.
module tb_rc5_key_mix;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        busy, done;
   logic [1:0]  L_address;
   logic [31:0] L_sub_i;
   logic [4:0]  s_rd_addr = '0;
   logic [31:0] s_rd_data;
   logic [2:0]  state_dbg;

   logic [31:0] up_l [4];
   logic [31:0] exp_q [$];
   int          checks = 0;
   int          passes = 0;

   always #5 clk = ~clk;

   assign L_sub_i = up_l[L_address];

   rc5_key_mix dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .L_address (L_address),
      .L_sub_i   (L_sub_i),
      .s_rd_addr (s_rd_addr),
      .s_rd_data (s_rd_data),
      .state_dbg (state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
   endtask

   function automatic logic [31:0] rot(input logic [31:0] x, input int n);
      int m;
      m = n & 31;
      if (m == 0) return x;
      return (x << m) | (x >> (32 - m));
   endfunction

   task automatic push_golden(input logic [31:0] k0, k1, k2, k3);
      logic [31:0] s [26];
      logic [31:0] l [4];
      logic [31:0] a, b;
      int ii, jj;
      l[0] = k0; l[1] = k1; l[2] = k2; l[3] = k3;
      s[0] = 32'hB7E15163;
      for (int k = 1; k < 26; k++) s[k] = s[k-1] + 32'h9E3779B9;
      a = '0; b = '0; ii = 0; jj = 0;
      for (int n = 0; n < 78; n++) begin
         a = rot(s[ii] + a + b, 3);
         s[ii] = a;
         b = rot(l[jj] + a + b, int'((a + b) & 32'd31));
         l[jj] = b;
         ii = (ii + 1) % 26;
         jj = (jj + 1) % 4;
      end
      for (int k = 0; k < 26; k++) exp_q.push_back(s[k]);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic run_key(input logic [31:0] k0, k1, k2, k3, input bit extra);
      int cyc;
      up_l[0] = k0; up_l[1] = k1; up_l[2] = k2; up_l[3] = k3;
      push_golden(k0, k1, k2, k3);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("done_after_start", 32'(done), 32'd0);
      cyc = 0;
      while (busy === 1'b1 && cyc < 300) begin
         cyc++;
         if (cyc <= 4) check("l_address_step", 32'(L_address), 32'(cyc - 1));
         if (cyc % 20 == 0) begin
            s_rd_addr = 5'(26 + (cyc % 6));
            #1 check("oor_read_busy", s_rd_data, 32'd0);
         end
         start = extra && (cyc == 1 || cyc == 50 || cyc == 107);
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("busy_cycles", 32'(cyc), 32'd108);
      check("done_high", 32'(done), 32'd1);
      check("busy_low", 32'(busy), 32'd0);
      for (int k = 0; k < 26; k++) begin
         s_rd_addr = 5'(k);
         #1;
         if (exp_q.size() == 0) check("sb_underflow", 32'd0, 32'd1);
         else check("s_word", s_rd_data, exp_q.pop_front());
      end
   endtask

   initial begin
      for (int k = 0; k < 4; k++) up_l[k] = '0;

      do_reset();
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_l_address", 32'(L_address), 32'd0);
      check("reset_state", 32'(state_dbg), 32'd0);

      // zero key, plain run
      run_key('0, '0, '0, '0, 1'b0);

      // single MIX iteration, then reset
      do_reset();
      for (int k = 0; k < 4; k++) up_l[k] = '0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (30) @(posedge clk);
      #1 check("first_mix_state", 32'(state_dbg), 32'd3);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      check("mid_reset_busy", 32'(busy), 32'd0);
      check("mid_reset_done", 32'(done), 32'd0);
      s_rd_addr = 5'd0; #1 check("one_iter_s0", s_rd_data, 32'hBF0A8B1D);
      s_rd_addr = 5'd1; #1 check("one_iter_s1", s_rd_data, 32'h5618CB1C);
      s_rd_addr = 5'd2; #1 check("one_iter_s2", s_rd_data, 32'hB7E15163 + 32'h9E3779B9 + 32'h9E3779B9);

      // nonzero key from IDLE
      run_key(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 1'b0);

      // extra start pulses while busy; also a restart from DONE
      run_key('0, '0, '0, '0, 1'b1);

      // restart from DONE with a random key
      run_key($urandom, $urandom, $urandom, $urandom, 1'b0);

      for (int k = 26; k < 32; k++) begin
         s_rd_addr = 5'(k);
         #1 check("oor_read_done", s_rd_data, 32'd0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/rc5_key_mix.md
Name: rc5_key_mix

Overview:
- Second half of the RC5 key expansion. Sits directly downstream of the key-bytes-to-words stage.
- Reads the c finished L words from the upstream L array, initialises the t-entry S table with the magic constants P and Q, then runs the 3*max(t,c) mixing loop.
- Afterwards it holds the expanded S table behind a read port for the encrypt/decrypt datapath.
- One clock domain; one mixing iteration per cycle.

Parameters:
- w, 32: word width in bits; the rotate amount uses the low log2(w) bits.
- w_log, 5: log2(w).
- r, 12: number of rounds.
- t, 26: S table size, 2*(r+1).
- t_length, 5: S index width.
- c, 4: number of L words.
- c_length, 2: L index width.
- P, 32'hB7E15163: magic constant Pw.
- Q, 32'h9E3779B9: magic constant Qw.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-low reset.
- start, input, 1: one-cycle pulse that launches an expansion; sampled only in IDLE or DONE.
- busy, output, 1: high from the cycle after start is accepted until the last MIX cycle.
- done, output, 1: high from the cycle after the last MIX cycle until the next accepted start or reset.
- L_address, output, c_length: word index into the upstream L array.
- L_sub_i, input, w: L word at L_address; combinational read, valid in the same cycle.
- s_rd_addr, input, t_length: S table read index.
- s_rd_data, output, w: S[s_rd_addr], combinational; reads 0 when s_rd_addr >= t.

Behaviour:
- States: IDLE -> LOAD_L -> INIT_S -> MIX -> DONE.
- Reset (rst==0 at a clock edge):
  - state=IDLE; busy=0; done=0; L_address=0; all counters 0; A=0; B=0.
  - Internal S[] and L[] arrays are not reset: they keep their contents and remain readable.
  - Reset is honoured in any state, including mid-MIX.
- IDLE/DONE:
  - start=1 -> LOAD_L, with busy=1 and done=0 from the next cycle.
  - start=0 -> hold state.
- LOAD_L, c cycles, k=0..c-1:
  - L_address=k; L[k] <= L_sub_i at the edge.
  - After k=c-1 -> INIT_S.
- INIT_S, t cycles, k=0..t-1:
  - S[0] <= P.
  - S[k] <= S[k-1] + Q, mod 2^w.
  - After k=t-1 -> MIX, with i=j=0 and A=B=0.
- MIX, exactly 3*max(t,c) cycles; each cycle, using current A, B, i, j:
  - A' = rotl(S[i] + A + B, 3); S[i] <= A'; A <= A'.
  - B' = rotl(L[j] + A' + B, (A'+B) mod w); L[j] <= B'; B <= B'.
  - i <= (i+1==t) ? 0 : i+1.
  - j <= (j+1==c) ? 0 : j+1.
  - All additions mod 2^w. Rotation amount 0 leaves the value unchanged.
- End of MIX: after the last MIX cycle -> DONE, with busy=0 and done=1.
- Cycle counts:
  - Total busy time = c + t + 3*max(t,c) cycles; 108 for the defaults.
  - done is visible on the edge after the last busy cycle.
- start while busy is ignored.
- start in DONE restarts a full expansion; the S table is overwritten progressively.
- s_rd_data is valid at any time. The downstream stage only consumes it while done=1.
- L_address holds 0 outside LOAD_L.

Test Plan:
- Basic run:
  - Stimulus: rst low 2 cycles, then start pulse with upstream L = {0,0,0,0}.
  - Required: busy high exactly 108 cycles, then done=1, busy=0.
  - Required: all 26 S words match the C golden model of RC5-32/12/16 with an all-zero key.
- Single-iteration check:
  - Stimulus: zero L; pull rst low in the cycle after the first MIX cycle.
  - Required: s_rd_addr=0 returns 32'hBF0A8B1D; s_rd_addr=1 returns 32'h5618CB1C (untouched init value); busy=0 and done=0.
- Nonzero key:
  - Stimulus: L = {32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C}.
  - Required: final S matches the golden model.
  - Required: L_address steps 0,1,2,3 in the first 4 busy cycles.
- Start ignored while busy:
  - Stimulus: extra start pulses at busy cycles 1, 50 and 107.
  - Required: done still rises after exactly 108 busy cycles; S identical to a single run.
- Restart from DONE:
  - Stimulus: second start with a different L after done.
  - Required: done drops the next cycle; new S matches the golden model for the new key.
- Out-of-range read:
  - Stimulus: s_rd_addr=26..31 in any state.
  - Required: s_rd_data=0.
